// File: rtl/mcycle_issue_ctrl.sv
// -----------------------------------------------------------------------------
// mcycle_issue_ctrl
// Issue / writeback controller for the multi-cycle execution units
// (unit 0 = MCycle mul/div, unit 1 = float add/mul by default).
// Each unit runs a small IDLE -> RUN -> DONE -> IDLE FSM, latches the
// destination register of its op and runs a watchdog counter. A pending
// scoreboard with one bit per architectural register stalls Decode on
// RAW/WAW hazards. Finished units are drained one per cycle through a
// lowest-index-first writeback arbiter.
//
// Ports
//   CLK, RESET    clock, synchronous active-high reset
//   IssueValidD   Decode requests a multi-cycle op
//   IssueUnitD    one-hot target unit (lowest set bit wins, zero = no issue)
//   IssueRdD      destination register of the op
//   SrcRegD       {B,A} source registers of the Decode instruction
//   SrcUseD       per-source valid for SrcRegD
//   FlushD        kill the Decode instruction this cycle
//   UnitDone      per-unit one-cycle result-ready pulse
//   Start         one-cycle start pulse per unit
//   StallD        hold Fetch/Decode (combinational)
//   Busy          unit not IDLE
//   WbValid       multi-cycle writeback this cycle
//   WbRd          writeback destination register
//   WbUnit        one-hot source unit of the writeback
//   TimeoutErr    sticky watchdog error
// -----------------------------------------------------------------------------
module mcycle_issue_ctrl #(
    parameter int N_UNITS = 2,
    parameter int REG_W   = 4,
    parameter int MAX_CYC = 40
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 IssueValidD,
    input  logic [N_UNITS-1:0]   IssueUnitD,
    input  logic [REG_W-1:0]     IssueRdD,
    input  logic [2*REG_W-1:0]   SrcRegD,
    input  logic [1:0]           SrcUseD,
    input  logic                 FlushD,
    input  logic [N_UNITS-1:0]   UnitDone,
    output logic [N_UNITS-1:0]   Start,
    output logic                 StallD,
    output logic [N_UNITS-1:0]   Busy,
    output logic                 WbValid,
    output logic [REG_W-1:0]     WbRd,
    output logic [N_UNITS-1:0]   WbUnit,
    output logic                 TimeoutErr
);

    localparam int CNT_W  = $clog2(MAX_CYC + 1);
    localparam int N_REGS = 1 << REG_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } unit_state_e;

    unit_state_e        state      [N_UNITS];
    unit_state_e        state_next [N_UNITS];
    logic [REG_W-1:0]   rd_q       [N_UNITS];
    logic [CNT_W-1:0]   cnt_q      [N_UNITS];
    logic [N_REGS-1:0]  pending_q;
    logic [N_REGS-1:0]  pending_next;

    logic [N_UNITS-1:0] busy;
    logic [N_UNITS-1:0] done_vec;
    logic [N_UNITS-1:0] timeout_vec;
    logic [N_UNITS-1:0] issue_sel;
    logic [N_UNITS-1:0] accept_vec;
    logic [N_UNITS-1:0] wb_sel;
    logic [REG_W-1:0]   wb_rd;
    logic [REG_W-1:0]   src_a;
    logic [REG_W-1:0]   src_b;
    logic               target_busy;
    logic               src_stall;
    logic               accept;

    // Per-unit status decode. A timeout fires in the last permitted RUN
    // cycle unless the unit reports done in that same cycle.
    always_comb begin
        for (int u = 0; u < N_UNITS; u++) begin
            busy[u]        = (state[u] != IDLE);
            done_vec[u]    = (state[u] == DONE);
            timeout_vec[u] = (state[u] == RUN) && !UnitDone[u] &&
                             (cnt_q[u] == CNT_W'(MAX_CYC - 1));
        end
    end

    assign Busy = busy;

    // x & -x isolates the lowest set bit: used for both the issue target
    // and the writeback arbiter.
    assign issue_sel = IssueUnitD & (~IssueUnitD + N_UNITS'(1));
    assign wb_sel    = done_vec   & (~done_vec   + N_UNITS'(1));

    always_comb begin
        wb_rd = '0;
        for (int u = 0; u < N_UNITS; u++) begin
            if (wb_sel[u]) begin
                wb_rd = wb_rd | rd_q[u];
            end
        end
    end

    // Hazard detection uses only the registered scoreboard, so a register
    // being retired this cycle still blocks its readers for this cycle.
    assign src_a       = SrcRegD[REG_W-1:0];
    assign src_b       = SrcRegD[2*REG_W-1:REG_W];
    assign src_stall   = (SrcUseD[0] && pending_q[src_a]) ||
                         (SrcUseD[1] && pending_q[src_b]);
    assign target_busy = |(issue_sel & busy);
    assign StallD      = !FlushD &&
                         (src_stall || (IssueValidD && (target_busy || pending_q[IssueRdD])));
    assign accept      = IssueValidD && (|issue_sel) && !StallD && !FlushD;
    assign accept_vec  = accept ? issue_sel : '0;

    // Unit FSM state register
    always_ff @(posedge CLK) begin
        for (int u = 0; u < N_UNITS; u++) begin
            if (RESET) begin
                state[u] <= IDLE;
            end else begin
                state[u] <= state_next[u];
            end
        end
    end

    // Unit FSM next-state logic; UnitDone outside RUN is ignored
    always_comb begin
        for (int u = 0; u < N_UNITS; u++) begin
            state_next[u] = state[u];
            case (state[u])
                IDLE: if (accept_vec[u]) state_next[u] = RUN;
                RUN: begin
                    if (UnitDone[u]) begin
                        state_next[u] = DONE;
                    end else if (timeout_vec[u]) begin
                        state_next[u] = IDLE;
                    end
                end
                DONE: if (wb_sel[u]) state_next[u] = IDLE;
                default: state_next[u] = IDLE;
            endcase
        end
    end

    // Watchdog counter and destination latch per unit
    always_ff @(posedge CLK) begin
        for (int u = 0; u < N_UNITS; u++) begin
            if (RESET) begin
                cnt_q[u] <= '0;
                rd_q[u]  <= '0;
            end else begin
                if (state[u] == RUN && state_next[u] == RUN) begin
                    cnt_q[u] <= cnt_q[u] + CNT_W'(1);
                end else begin
                    cnt_q[u] <= '0;
                end
                if (accept_vec[u]) begin
                    rd_q[u] <= IssueRdD;
                end
            end
        end
    end

    // Scoreboard update. Set and clear never target the same register,
    // because an issue whose Rd is still pending is stalled.
    always_comb begin
        pending_next = pending_q;
        for (int u = 0; u < N_UNITS; u++) begin
            if (timeout_vec[u]) begin
                pending_next[rd_q[u]] = 1'b0;
            end
        end
        if (|wb_sel) begin
            pending_next[wb_rd] = 1'b0;
        end
        if (accept) begin
            pending_next[IssueRdD] = 1'b1;
        end
    end

    // Registered outputs and scoreboard
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pending_q  <= '0;
            Start      <= '0;
            WbValid    <= 1'b0;
            WbRd       <= '0;
            WbUnit     <= '0;
            TimeoutErr <= 1'b0;
        end else begin
            pending_q  <= pending_next;
            Start      <= accept_vec;
            WbValid    <= |wb_sel;
            WbRd       <= wb_rd;
            WbUnit     <= wb_sel;
            TimeoutErr <= TimeoutErr | (|timeout_vec);
        end
    end

endmodule

// File: tb/tb_mcycle_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mcycle_issue_ctrl
// Self-checking bench for mcycle_issue_ctrl. A behavioural model tracks each
// unit as "active / finished / age / rd" plus a per-register pending array
// and predicts every output each cycle. Directed scenarios come first,
// followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_mcycle_issue_ctrl;

    localparam int N_UNITS = 2;
    localparam int REG_W   = 4;
    localparam int MAX_CYC = 40;
    localparam int N_REGS  = 16;

    logic               CLK = 1'b0;
    logic               RESET;
    logic               IssueValidD;
    logic [N_UNITS-1:0] IssueUnitD;
    logic [REG_W-1:0]   IssueRdD;
    logic [2*REG_W-1:0] SrcRegD;
    logic [1:0]         SrcUseD;
    logic               FlushD;
    logic [N_UNITS-1:0] UnitDone;
    logic [N_UNITS-1:0] Start;
    logic               StallD;
    logic [N_UNITS-1:0] Busy;
    logic               WbValid;
    logic [REG_W-1:0]   WbRd;
    logic [N_UNITS-1:0] WbUnit;
    logic               TimeoutErr;

    mcycle_issue_ctrl #(
        .N_UNITS (N_UNITS),
        .REG_W   (REG_W),
        .MAX_CYC (MAX_CYC)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .IssueValidD (IssueValidD),
        .IssueUnitD  (IssueUnitD),
        .IssueRdD    (IssueRdD),
        .SrcRegD     (SrcRegD),
        .SrcUseD     (SrcUseD),
        .FlushD      (FlushD),
        .UnitDone    (UnitDone),
        .Start       (Start),
        .StallD      (StallD),
        .Busy        (Busy),
        .WbValid     (WbValid),
        .WbRd        (WbRd),
        .WbUnit      (WbUnit),
        .TimeoutErr  (TimeoutErr)
    );

    always #5 CLK = ~CLK;

    // Reference model state
    bit               mActive   [N_UNITS];
    bit               mFinished [N_UNITS];
    int               mAge      [N_UNITS];
    logic [REG_W-1:0] mRd       [N_UNITS];
    bit               mPending  [N_REGS];
    logic [1:0]       expStart;
    logic             expWbValid;
    logic [3:0]       expWbRd;
    logic [1:0]       expWbUnit;
    logic             expErr;

    int vectorCount = 0;
    int errCount    = 0;

    function automatic int lowestUnit(input logic [N_UNITS-1:0] v);
        for (int i = 0; i < N_UNITS; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Decode must hold on any hazard against in-flight results, unless flushed
    function automatic bit modelStall();
        int t;
        bit s;
        t = lowestUnit(IssueUnitD);
        s = 1'b0;
        if (SrcUseD[0] && mPending[SrcRegD[3:0]]) s = 1'b1;
        if (SrcUseD[1] && mPending[SrcRegD[7:4]]) s = 1'b1;
        if (IssueValidD && t >= 0 && mActive[t]) s = 1'b1;
        if (IssueValidD && mPending[IssueRdD]) s = 1'b1;
        if (FlushD) s = 1'b0;
        return s;
    endfunction

    function automatic logic [1:0] modelBusy();
        logic [1:0] b;
        for (int i = 0; i < N_UNITS; i++) b[i] = mActive[i];
        return b;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < N_UNITS; i++) begin
            mActive[i]   = 1'b0;
            mFinished[i] = 1'b0;
            mAge[i]      = 0;
            mRd[i]       = '0;
        end
        for (int r = 0; r < N_REGS; r++) mPending[r] = 1'b0;
        expStart   = '0;
        expWbValid = 1'b0;
        expWbRd    = '0;
        expWbUnit  = '0;
        expErr     = 1'b0;
    endtask

    // Advance the model across one rising edge using the current inputs
    task automatic modelClock();
        bit stall;
        bit acc;
        int t;
        int wb;
        if (RESET) begin
            modelReset();
            return;
        end
        stall = modelStall();
        t     = lowestUnit(IssueUnitD);
        acc   = IssueValidD && !stall && !FlushD && (t >= 0);
        wb    = -1;
        for (int i = N_UNITS - 1; i >= 0; i--) begin
            if (mFinished[i]) wb = i;
        end
        expStart   = '0;
        expWbValid = 1'b0;
        expWbRd    = '0;
        expWbUnit  = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            if (mActive[i] && !mFinished[i]) begin
                if (UnitDone[i]) begin
                    mFinished[i] = 1'b1;
                end else begin
                    mAge[i]++;
                    if (mAge[i] == MAX_CYC) begin
                        mActive[i]        = 1'b0;
                        mPending[mRd[i]]  = 1'b0;
                        expErr            = 1'b1;
                    end
                end
            end
        end
        if (wb >= 0) begin
            expWbValid        = 1'b1;
            expWbRd           = mRd[wb];
            expWbUnit[wb]     = 1'b1;
            mActive[wb]       = 1'b0;
            mFinished[wb]     = 1'b0;
            mPending[mRd[wb]] = 1'b0;
        end
        if (acc) begin
            mActive[t]         = 1'b1;
            mFinished[t]       = 1'b0;
            mAge[t]            = 0;
            mRd[t]             = IssueRdD;
            mPending[IssueRdD] = 1'b1;
            expStart[t]        = 1'b1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectorCount++;
        assert (obs === exp) else begin
            errCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, compare all outputs, then step the model
    task automatic applyStimulus(input bit v, input logic [1:0] unit, input logic [3:0] rd,
                                 input logic [7:0] src, input logic [1:0] use_, input bit flush,
                                 input logic [1:0] done, input bit rst);
        @(negedge CLK);
        IssueValidD = v;
        IssueUnitD  = unit;
        IssueRdD    = rd;
        SrcRegD     = src;
        SrcUseD     = use_;
        FlushD      = flush;
        UnitDone    = done;
        RESET       = rst;
        #1;
        checkOutput("StallD",     32'(StallD),     32'(modelStall()));
        checkOutput("Start",      32'(Start),      32'(expStart));
        checkOutput("Busy",       32'(Busy),       32'(modelBusy()));
        checkOutput("WbValid",    32'(WbValid),    32'(expWbValid));
        checkOutput("WbRd",       32'(WbRd),       32'(expWbRd));
        checkOutput("WbUnit",     32'(WbUnit),     32'(expWbUnit));
        checkOutput("TimeoutErr", 32'(TimeoutErr), 32'(expErr));
        @(posedge CLK);
        modelClock();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 2'b00, 4'd0, 8'd0, 2'b00, 0, 2'b00, 0);
    endtask

    initial begin
        RESET       = 1'b1;
        IssueValidD = 1'b0;
        IssueUnitD  = '0;
        IssueRdD    = '0;
        SrcRegD     = '0;
        SrcUseD     = '0;
        FlushD      = 1'b0;
        UnitDone    = '0;
        repeat (2) @(posedge CLK);
        modelReset();
        $display("[TB] reset released, starting directed scenarios");

        // Single op on unit 0: start pulse, writeback timing, scoreboard release
        applyStimulus(1, 2'b01, 4'd5, 8'h00, 2'b00, 0, 2'b00, 0);
        #1 checkOutput("start_t1", 32'(Start), 32'h1);
        idle(5);
        applyStimulus(0, 2'b00, 4'd0, 8'h00, 2'b00, 0, 2'b01, 0);
        idle(1);
        #1;
        checkOutput("wb_valid_t8", 32'(WbValid), 32'h1);
        checkOutput("wb_rd_t8",    32'(WbRd),    32'h5);
        checkOutput("wb_unit_t8",  32'(WbUnit),  32'h1);
        applyStimulus(1, 2'b10, 4'd6, 8'h05, 2'b01, 0, 2'b00, 0);
        #1 checkOutput("r5_free_issue", 32'(Start), 32'h2);
        idle(2);
        applyStimulus(0, 2'b00, 4'd0, 8'h00, 2'b00, 0, 2'b10, 0);
        idle(2);

        // RAW hazard on r5 and flush suppression
        applyStimulus(1, 2'b01, 4'd5, 8'h00, 2'b00, 0, 2'b00, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 2'b00, 4'd0, 8'h05, 2'b01, 0, 2'b00, 0);
        applyStimulus(1, 2'b10, 4'd9, 8'h05, 2'b01, 1, 2'b00, 0);
        applyStimulus(0, 2'b00, 4'd0, 8'h05, 2'b01, 0, 2'b01, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 2'b00, 4'd0, 8'h05, 2'b01, 0, 2'b00, 0);

        // Simultaneous completion: unit 0 drains first, unit 1 next cycle
        applyStimulus(1, 2'b01, 4'd1, 8'h00, 2'b00, 0, 2'b00, 0);
        applyStimulus(1, 2'b10, 4'd2, 8'h00, 2'b00, 0, 2'b00, 0);
        idle(1);
        applyStimulus(0, 2'b00, 4'd0, 8'h00, 2'b00, 0, 2'b11, 0);
        idle(1);
        #1;
        checkOutput("dual_wb0_unit", 32'(WbUnit), 32'h1);
        checkOutput("dual_wb0_rd",   32'(WbRd),   32'h1);
        idle(1);
        #1;
        checkOutput("dual_wb1_valid", 32'(WbValid), 32'h1);
        checkOutput("dual_wb1_unit",  32'(WbUnit),  32'h2);
        checkOutput("dual_wb1_rd",    32'(WbRd),    32'h2);
        idle(2);

        // Watchdog on unit 1 with a reader waiting on r7
        applyStimulus(1, 2'b10, 4'd7, 8'h00, 2'b00, 0, 2'b00, 0);
        for (int i = 0; i < MAX_CYC + 2; i++) applyStimulus(0, 2'b00, 4'd0, 8'h07, 2'b01, 0, 2'b00, 0);
        #1;
        checkOutput("timeout_err",  32'(TimeoutErr), 32'h1);
        checkOutput("timeout_busy", 32'(Busy),       32'h0);
        checkOutput("timeout_stall", 32'(StallD),    32'h0);

        // Reset mid-operation abandons the op; late done pulse is ignored
        applyStimulus(1, 2'b01, 4'd3, 8'h00, 2'b00, 0, 2'b00, 0);
        idle(2);
        applyStimulus(0, 2'b00, 4'd0, 8'h00, 2'b00, 0, 2'b00, 1);
        applyStimulus(0, 2'b00, 4'd0, 8'h00, 2'b00, 0, 2'b01, 0);
        idle(2);
        #1;
        checkOutput("rst_busy",    32'(Busy),       32'h0);
        checkOutput("rst_wbvalid", 32'(WbValid),    32'h0);
        checkOutput("rst_err",     32'(TimeoutErr), 32'h0);
        applyStimulus(1, 2'b01, 4'd3, 8'h33, 2'b11, 0, 2'b00, 0);
        #1 checkOutput("rst_sb_empty", 32'(Start), 32'h1);
        idle(1);

        // Randomized phase; a quiet window lets watchdog timeouts happen
        $display("[TB] starting randomized phase");
        for (int c = 0; c < 600; c++) begin
            logic [1:0] dn;
            bit quiet;
            quiet = (c >= 250 && c < 330);
            dn[0] = !quiet && ($urandom_range(0, 5) == 0);
            dn[1] = !quiet && ($urandom_range(0, 5) == 0);
            applyStimulus($urandom_range(0, 9) < 6,
                          2'($urandom_range(0, 3)),
                          4'($urandom_range(0, 15)),
                          8'($urandom),
                          2'($urandom_range(0, 3)),
                          $urandom_range(0, 9) == 0,
                          dn,
                          $urandom_range(0, 149) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, errCount);
        $finish;
    end

endmodule
